// File: rtl/write_data_if.sv
// Pixel-pair stream and buffer read port of the write_data frame capture block.
// The master drives the stream and read address; the capture block is the slave.
interface write_data_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  vertical_Pulse;
    logic                  horizontal_Pulse;
    logic [7:0]            data_Red_Even;
    logic [7:0]            data_Green_Even;
    logic [7:0]            data_Blue_Even;
    logic [7:0]            data_Red_Odd;
    logic [7:0]            data_Green_Odd;
    logic [7:0]            data_Blue_Odd;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  write_done;
    logic                  frame_error;

    modport master (
        output vertical_Pulse, horizontal_Pulse,
        output data_Red_Even, data_Green_Even, data_Blue_Even,
        output data_Red_Odd, data_Green_Odd, data_Blue_Odd,
        output rd_addr,
        input  rd_data, write_done, frame_error
    );

    modport slave (
        input  vertical_Pulse, horizontal_Pulse,
        input  data_Red_Even, data_Green_Even, data_Blue_Even,
        input  data_Red_Odd, data_Green_Odd, data_Blue_Odd,
        input  rd_addr,
        output rd_data, write_done, frame_error
    );
endinterface

// File: rtl/write_data.sv
// Captures even/odd RGB pixel pairs into a bottom-up, 3-byte-per-pixel frame buffer
// with a registered byte read port, so the buffer matches the source hex image layout.
module write_data #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int ADDR_WIDTH   = 21
) (
    input logic        clk,
    input logic        reset,
    write_data_if.slave bus
);
    localparam int DEPTH     = IMAGE_WIDTH * IMAGE_HEIGHT * 3;
    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam int WIDE      = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [10:0]           r_column;
    logic [9:0]            r_row;
    logic                  r_frameError;
    logic [7:0]            r_rdData;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_writeEn;
    logic                  w_errorSet;
    logic                  w_writeDone;
    logic                  w_lastPair;
    logic                  w_rdValid;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_byteAddr  [6];
    logic                  w_byteValid [6];
    logic [7:0]            w_pairBytes [6];

    assign w_lastPair = (r_row == 10'(IMAGE_HEIGHT - 1)) && (r_column == 11'(IMAGE_WIDTH - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // vertical_Pulse outranks horizontal_Pulse in every state
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.vertical_Pulse) w_nextState = CAPTURE;
            CAPTURE: if (!bus.vertical_Pulse && bus.horizontal_Pulse && w_lastPair) w_nextState = DONE;
            DONE:    if (bus.vertical_Pulse) w_nextState = CAPTURE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_writeEn   = 1'b0;
        w_errorSet  = 1'b0;
        w_writeDone = 1'b0;
        case (r_state)
            CAPTURE: w_writeEn   = !bus.vertical_Pulse && bus.horizontal_Pulse;
            DONE:    w_writeDone = 1'b1;
            default: ;
        endcase
        if (r_state != CAPTURE && !bus.vertical_Pulse && bus.horizontal_Pulse) w_errorSet = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_column <= '0;
            r_row    <= '0;
        end else if (bus.vertical_Pulse) begin
            r_column <= '0;
            r_row    <= '0;
        end else if (w_writeEn) begin
            if (r_column == 11'(IMAGE_WIDTH - 2)) begin
                r_column <= '0;
                r_row    <= r_row + 10'd1;
            end else begin
                r_column <= r_column + 11'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_frameError <= 1'b0;
        else if (w_errorSet) r_frameError <= 1'b1;
    end

    // Row 0 of the stream lands in the last buffer row (bottom-up layout)
    assign w_base = ADDR_WIDTH'(WIDE'(3 * IMAGE_WIDTH) * (WIDE'(IMAGE_HEIGHT - 1) - WIDE'(r_row))
                                + WIDE'(3) * WIDE'(r_column));

    always_comb begin
        w_pairBytes[0] = bus.data_Red_Even;
        w_pairBytes[1] = bus.data_Green_Even;
        w_pairBytes[2] = bus.data_Blue_Even;
        w_pairBytes[3] = bus.data_Red_Odd;
        w_pairBytes[4] = bus.data_Green_Odd;
        w_pairBytes[5] = bus.data_Blue_Odd;
        for (int k = 0; k < 6; k++) begin
            w_byteAddr[k]  = w_base + ADDR_WIDTH'(k);
            w_byteValid[k] = 32'(w_byteAddr[k]) < DEPTH;
        end
    end

    // Buffer contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_writeEn) begin
            for (int k = 0; k < 6; k++) begin
                if (w_byteValid[k]) r_mem[w_byteAddr[k][IDX_WIDTH-1:0]] <= w_pairBytes[k];
            end
        end
    end

    assign w_rdValid = 32'(bus.rd_addr) < DEPTH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rdData <= 8'd0;
        else        r_rdData <= w_rdValid ? r_mem[bus.rd_addr[IDX_WIDTH-1:0]] : 8'd0;
    end

    assign bus.rd_data     = r_rdData;
    assign bus.write_done  = w_writeDone;
    assign bus.frame_error = r_frameError;
endmodule

// File: tb/tb_write_data.sv
// Directed bench for write_data on a 4x2 frame: a byte model of the buffer feeds a
// scoreboard queue of expected read-port bytes, popped as the registered read returns.
module tb_write_data;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int AW    = 5;
    localparam int DEPTH = 24;

    typedef struct {
        int         addr;
        logic [7:0] expByte;
    } sbEntry_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    sbEntry_t   sbQ [$];
    logic [7:0] model [DEPTH];
    int   pairBase [4] = '{12, 18, 0, 6};

    write_data_if #(.ADDR_WIDTH(AW)) bus ();

    write_data #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] tagBytes(input logic [3:0] tag);
        return {tag, 4'h1, tag, 4'h2, tag, 4'h3, tag, 4'h4, tag, 4'h5, tag, 4'h6};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setPairData(input logic [47:0] b);
        bus.data_Red_Even   = b[47:40];
        bus.data_Green_Even = b[39:32];
        bus.data_Blue_Even  = b[31:24];
        bus.data_Red_Odd    = b[23:16];
        bus.data_Green_Odd  = b[15:8];
        bus.data_Blue_Odd   = b[7:0];
    endtask

    task automatic applyStimulus(input logic [47:0] b);
        @(negedge clk);
        bus.vertical_Pulse   = 1'b0;
        bus.horizontal_Pulse = 1'b1;
        setPairData(b);
    endtask

    task automatic modelPair(input int k, input logic [47:0] b);
        for (int i = 0; i < 6; i++) model[pairBase[k] + i] = b[47 - 8*i -: 8];
    endtask

    task automatic sendFramePair(input int k, input logic [47:0] b);
        modelPair(k, b);
        applyStimulus(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.vertical_Pulse   = 1'b0;
            bus.horizontal_Pulse = 1'b0;
        end
    endtask

    task automatic frameStart();
        @(negedge clk);
        bus.vertical_Pulse   = 1'b1;
        bus.horizontal_Pulse = 1'b0;
    endtask

    task automatic readByte(input int a);
        sbEntry_t e;
        @(negedge clk);
        bus.vertical_Pulse   = 1'b0;
        bus.horizontal_Pulse = 1'b0;
        bus.rd_addr          = AW'(a);
        sbQ.push_back('{a, model[a]});
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        checkOutput($sformatf("rd_data[%0d]", e.addr), bus.rd_data, e.expByte);
    endtask

    task automatic checkAll();
        for (int a = 0; a < DEPTH; a++) readByte(a);
    endtask

    initial begin
        sbEntry_t e;
        bus.vertical_Pulse   = 1'b0;
        bus.horizontal_Pulse = 1'b0;
        bus.rd_addr          = '0;
        setPairData('0);

        #12;
        checkOutput("reset rd_data", bus.rd_data, 8'd0);
        checkOutput("reset write_done", {7'd0, bus.write_done}, 8'd0);
        checkOutput("reset frame_error", {7'd0, bus.frame_error}, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] first pair");
        frameStart();
        sendFramePair(0, 48'h11_12_13_21_22_23);
        for (int a = 12; a < 18; a++) readByte(a);
        checkOutput("first write_done", {7'd0, bus.write_done}, 8'd0);

        $display("[TB] full frame back-to-back");
        frameStart();
        for (int k = 0; k < 3; k++) sendFramePair(k, tagBytes(4'(k + 1)));
        sendFramePair(3, tagBytes(4'h4));
        #1;
        checkOutput("done before last edge", {7'd0, bus.write_done}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("done on last edge", {7'd0, bus.write_done}, 8'd1);
        checkAll();

        $display("[TB] gapped frame and extra pair");
        frameStart();
        for (int k = 0; k < 4; k++) begin
            idle(int'($urandom_range(5, 0)));
            sendFramePair(k, tagBytes(4'(k + 5)));
        end
        idle(1);
        checkOutput("gapped write_done", {7'd0, bus.write_done}, 8'd1);
        applyStimulus(tagBytes(4'h9));
        idle(1);
        checkOutput("extra pair frame_error", {7'd0, bus.frame_error}, 8'd1);
        checkAll();

        $display("[TB] mid-frame restart");
        frameStart();
        @(posedge clk);
        #1;
        checkOutput("restart clears done", {7'd0, bus.write_done}, 8'd0);
        sendFramePair(0, tagBytes(4'hA));
        sendFramePair(1, tagBytes(4'hB));
        frameStart();
        for (int k = 0; k < 4; k++) sendFramePair(k, tagBytes(4'(k + 12)));
        idle(1);
        checkOutput("restart write_done", {7'd0, bus.write_done}, 8'd1);
        checkOutput("frame_error sticky", {7'd0, bus.frame_error}, 8'd1);
        checkAll();

        $display("[TB] reset mid-frame and error cases");
        frameStart();
        for (int k = 0; k < 3; k++) sendFramePair(k, tagBytes(4'(k + 1)));
        @(negedge clk);
        bus.horizontal_Pulse = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset rd_data", bus.rd_data, 8'd0);
        checkOutput("async reset write_done", {7'd0, bus.write_done}, 8'd0);
        checkOutput("async reset frame_error", {7'd0, bus.frame_error}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(tagBytes(4'h0));
        idle(1);
        checkOutput("idle pair frame_error", {7'd0, bus.frame_error}, 8'd1);
        checkOutput("idle pair write_done", {7'd0, bus.write_done}, 8'd0);
        checkAll();

        frameStart();
        @(negedge clk);
        bus.vertical_Pulse   = 1'b0;
        bus.horizontal_Pulse = 1'b1;
        setPairData(tagBytes(4'h9));
        bus.rd_addr = AW'(12);
        sbQ.push_back('{12, model[12]});
        modelPair(0, tagBytes(4'h9));
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        checkOutput("collision old byte", bus.rd_data, e.expByte);
        readByte(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/write_data.md
# write_data

`write_data` is the receive end of the image pixel-pair stream. It captures even/odd RGB pixel pairs qualified by `horizontal_Pulse` and writes them into an internal byte frame buffer. The buffer uses the same layout as the input hex image: rows bottom-up, 3 bytes per pixel in R,G,B order. A round trip through the reader, the processing chain and this block therefore reproduces the source file byte-for-byte. A byte-wide registered read port lets the testbench or a downstream dumper drain the buffer, and `write_done` signals frame completion.

## Interface
Parameters:
- `IMAGE_WIDTH`, 768: pixels per row; must be even.
- `IMAGE_HEIGHT`, 512: rows per frame.
- `ADDR_WIDTH`, 21: read-address width; 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT*3.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `vertical_Pulse`  in  1  frame start, level; high for one or more cycles arms a new frame.
- `horizontal_Pulse`  in  1  pixel-pair valid; one pair accepted per high cycle.
- `data_Red_Even`, `data_Green_Even`, `data_Blue_Even`  in  8 each  pixel at even column.
- `data_Red_Odd`, `data_Green_Odd`, `data_Blue_Odd`  in  8 each  pixel at column+1.
- `rd_addr`  in  ADDR_WIDTH  buffer byte address.
- `rd_data`  out  8  registered buffer byte.
- `write_done`  out  1  level; full frame captured.
- `frame_error`  out  1  sticky; valid pair received outside CAPTURE.

## Operation
FSM states are IDLE, CAPTURE and DONE. The reset state is IDLE.
- **IDLE:**
  - `vertical_Pulse` high moves to CAPTURE and clears `column` and `row`.
  - `horizontal_Pulse` high in IDLE sets `frame_error`; the data is dropped.
- **CAPTURE:**
  - While `vertical_Pulse` is high, counters are held at 0 and no data is accepted.
  - When `vertical_Pulse` is low and `horizontal_Pulse` is high, 6 bytes are written starting at base = 3*IMAGE_WIDTH*(IMAGE_HEIGHT-1-row) + 3*column.
  - Byte order from base+0 to base+5: R_even, G_even, B_even, R_odd, G_odd, B_odd.
  - After a write, `column` += 2. At `column` == IMAGE_WIDTH-2, `column` wraps to 0 and `row` += 1.
  - The pair at `row` == IMAGE_HEIGHT-1 and `column` == IMAGE_WIDTH-2 is written and the FSM moves to DONE.
- **DONE:**
  - `write_done` = 1.
  - `horizontal_Pulse` high sets `frame_error`; the buffer is unchanged.
  - `vertical_Pulse` high clears `write_done` and moves to CAPTURE with counters cleared.
- **Mid-frame restart:** `vertical_Pulse` high while in CAPTURE aborts the frame. Counters return to 0. Bytes already written remain until overwritten.
- **Counter widths:** `column` is 11 bits and `row` is 10 bits, sized for up to 2048x1024.
- **Address arithmetic:** computed at ADDR_WIDTH+2 bits, then truncated to ADDR_WIDTH.
- **Read port:** `rd_data` <= buf[`rd_addr`] every cycle. An out-of-range address returns 0.
- **Read/write collision:** a read and a write to the same byte in the same cycle returns the old byte (read-before-write).
- **Buffer contents:** not cleared by reset; no initial contents are guaranteed.
- **Reset values:** `write_done` = 0, `frame_error` = 0, `rd_data` = 0, `column` = 0, `row` = 0. `frame_error` is cleared only by reset.

## Timing
- **Write latency:** a pair sampled at edge N is in the buffer after edge N. A read issued in cycle N+1 returns it at edge N+2.
- **Read latency:** 1 cycle from `rd_addr` to `rd_data`.
- **Done timing:** `write_done` rises on the edge that accepts the final pair.
- **Back-to-back input:** supported at 1 pair/cycle with no bubbles. The input has no backpressure.
- **Row gaps:** any number of idle cycles between pairs or rows is tolerated; the position is tracked only by counters.
- **Reset mid-operation:** asynchronous reset forces IDLE immediately, counters go to 0, and partially written data is left in the buffer.
- **Priority:** `vertical_Pulse` beats `horizontal_Pulse` in the same cycle, in every state.

## Test plan
Directed tests use IMAGE_WIDTH=4, IMAGE_HEIGHT=2, ADDR_WIDTH=5 (24-byte buffer).
1. **First pair:** `vertical_Pulse` pulse, then a pair with even RGB = 11/12/13 and odd RGB = 21/22/23 -> bytes 12..17 read back 11,12,13,21,22,23; `write_done` = 0.
2. **Full frame:** four pairs on consecutive cycles tagged 1x,2x,3x,4x -> bytes 12..17 = pair 1, 18..23 = pair 2, 0..5 = pair 3, 6..11 = pair 4. `write_done` rises on the edge accepting pair 4.
3. **Gaps and extra pair:** random 0-5 cycle gaps between pairs give the same buffer image as test 2. A 5th pair after done -> `frame_error` = 1 and the buffer is unchanged.
4. **Restart:** after 2 pairs, assert `vertical_Pulse`, then send 4 new pairs -> the buffer holds only the new frame and `write_done` = 1.
5. **Reset and error cases:**
   - Assert `reset` low after 3 pairs -> all outputs read 0 and the FSM is in IDLE.
   - A pair sent before any `vertical_Pulse` -> `frame_error` = 1.
   - Read and write to address 12 in the same cycle -> `rd_data` returns the old value.
6. **Full-size round trip:** IMAGE_WIDTH=768, IMAGE_HEIGHT=512, fed by the reader-generated stream of `input_picture.hex` -> all 1179648 dumped bytes equal the source file.
